branch_pred_unit: RTL and testbench
===================================

Name: branch_pred_unit

Overview:
- Fetch-side branch predictor and redirect generator that closes the loop with the execute-stage branch evaluator.
- IFU queries with a fetch PC and gets a registered taken/target prediction one cycle later.
- Execute stage returns each resolved branch outcome with the prediction it carried. The block trains a 2-bit BHT plus direct-mapped BTB and raises a held redirect to IFU on mispredict.

Parameters:
- XLEN, 32, data/PC width.
- BHT_DEPTH, 64, number of entries; power of 2, ≥ 4.
- IDX_W, $clog2(BHT_DEPTH), index width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- if_req_valid  in  1  IFU lookup request.
- if_req_pc  in  XLEN  fetch PC to predict.
- pred_valid  out  1  prediction valid (1 cycle after request).
- pred_taken  out  1  predicted taken.
- pred_target  out  XLEN  predicted target.
- ex_valid  in  1  resolved branch from execute.
- ex_pc  in  XLEN  PC of resolved branch.
- ex_taken  in  1  actual branch result from the branch evaluator.
- ex_target  in  XLEN  actual taken target.
- ex_pred_taken  in  1  prediction that instruction carried.
- ex_pred_target  in  XLEN  predicted target it carried.
- redirect_valid  out  1  redirect request to IFU.
- redirect_ready  in  1  IFU accepts redirect.
- redirect_pc  out  XLEN  correct next PC.
- flush  out  1  one-cycle pulse on mispredict detection.

Behaviour:
- Index: idx = pc[IDX_W+1:2]. There is no tag; aliasing is allowed.
- Storage per entry: cnt[1:0], btb_vld, btb_tgt[XLEN-1:0], all in flops.
- Reset values: cnt = 2'b01 (weakly not-taken), btb_vld = 0, btb_tgt = 0.
- Reset values of outputs: pred_valid = 0, pred_taken = 0, pred_target = 0, redirect_valid = 0, redirect_pc = 0, flush = 0.
- Reset asserted mid-operation aborts any pending redirect in the same cycle.
- Lookup:
  - Registered, latency 1: pred_valid <= if_req_valid.
  - pred_taken <= cnt[idx][1] & btb_vld[idx].
  - pred_target <= btb_tgt[idx].
  - When if_req_valid = 0, pred_taken/pred_target hold their previous values.
- Update, on ex_valid & ~redirect_valid:
  - Taken: cnt saturating increment, max 3. Not-taken: saturating decrement, min 0.
  - When taken: btb_tgt <= ex_target, btb_vld <= 1.
  - When not-taken, BTB is unchanged.
- Mispredict:
  - mis = ex_pred_taken != ex_taken, or (ex_taken & ex_pred_taken & ex_pred_target != ex_target).
  - On ex_valid & ~redirect_valid & mis, in the next cycle:
    - redirect_valid = 1;
    - redirect_pc = ex_taken ? ex_target : ex_pc + 4, modulo 2^XLEN (wraps);
    - flush = 1 for exactly that cycle.
- Redirect handshake:
  - redirect_valid and redirect_pc are held stable until a cycle with redirect_ready = 1; redirect_valid clears the next cycle.
  - redirect_ready is ignored while redirect_valid = 0.
- While redirect_valid = 1, ex_valid is treated as a wrong-path instruction: no training, no new redirect.
- In the acceptance cycle (redirect_valid & redirect_ready), ex_valid is still ignored.
- Same-cycle lookup and update to the same index: lookup registers the pre-update entry (read-old); the update takes effect for lookups from the next cycle.
- A correct prediction trains only: no flush, no redirect.

Test Plan:
- Reset, then lookup pc=0x100 → next cycle pred_valid=1, pred_taken=0, pred_target=0; redirect_valid=0.
- Training: ex pc=0x100, taken=1, target=0x200, pred_taken=0 → flush pulse 1 cycle, redirect_pc=0x200. Accept; resolve taken again with correct prediction → no redirect. Lookup 0x100 → pred_taken=1, pred_target=0x200. Five taken resolves leave cnt=3; three not-taken leave cnt=0 (saturation both ends).
- Backpressure: mispredict with redirect_ready=0 for 4 cycles → redirect_valid/redirect_pc stable for 4 cycles. Extra ex_valid pulses during that time → no counter change, no new redirect. Ready=1 → redirect_valid low next cycle.
- Not-taken wrap: ex pc=0xFFFFFFFC, taken=0, pred_taken=1 → redirect_pc=0x00000000.
- Target mismatch: pred_taken=1, taken=1, pred_target=0x300, target=0x400 → redirect_pc=0x400, BTB entry updated to 0x400.
- Collision/reset: lookup and update at 0x100 in the same cycle → old prediction returned. Assert rst while redirect pending → redirect_valid=0 next cycle; lookup 0x100 → pred_taken=0.

Source files
------------

// File: rtl/branch_pred_unit.sv
// Fetch-side 2-bit BHT + direct-mapped BTB predictor with execute-stage training
// and a held, handshaked redirect to the IFU on mispredict.
module branch_pred_unit #(
  parameter  int XLEN      = 32,
  parameter  int BHT_DEPTH = 64,
  localparam int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  input  logic [XLEN-1:0] if_req_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush
);

  logic [1:0]      cnt_reg     [BHT_DEPTH];
  logic            btb_vld_reg [BHT_DEPTH];
  logic [XLEN-1:0] btb_tgt_reg [BHT_DEPTH];

  logic            pred_valid_reg;
  logic            pred_taken_reg;
  logic [XLEN-1:0] pred_target_reg;
  logic            redirect_valid_reg;
  logic [XLEN-1:0] redirect_pc_reg;
  logic            flush_reg;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             upd_en;
  logic             mis;
  logic [XLEN-1:0]  redirect_pc_next;
  logic             unused_pc_bits;

  assign if_idx = if_req_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_req_pc[XLEN-1:IDX_W+2], if_req_pc[1:0]};

  // Anything resolving while a redirect is outstanding is wrong-path and ignored.
  assign upd_en = ex_valid & ~redirect_valid_reg;
  assign mis    = (ex_pred_taken != ex_taken) |
                  (ex_taken & ex_pred_taken & (ex_pred_target != ex_target));
  assign redirect_pc_next = ex_taken ? ex_target : ex_pc + XLEN'(4);

  generate
    for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg[gi]     <= 2'b01;
          btb_vld_reg[gi] <= 1'b0;
          btb_tgt_reg[gi] <= '0;
        end else if (upd_en && (ex_idx == IDX_W'(gi))) begin
          if (ex_taken) begin
            cnt_reg[gi]     <= (cnt_reg[gi] == 2'b11) ? 2'b11 : cnt_reg[gi] + 2'b01;
            btb_vld_reg[gi] <= 1'b1;
            btb_tgt_reg[gi] <= ex_target;
          end else begin
            cnt_reg[gi]     <= (cnt_reg[gi] == 2'b00) ? 2'b00 : cnt_reg[gi] - 2'b01;
          end
        end
      end
    end
  endgenerate

  // Lookup samples the table before this cycle's update lands (read-old).
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_reg  <= 1'b0;
      pred_taken_reg  <= 1'b0;
      pred_target_reg <= '0;
    end else begin
      pred_valid_reg <= if_req_valid;
      if (if_req_valid) begin
        pred_taken_reg  <= cnt_reg[if_idx][1] & btb_vld_reg[if_idx];
        pred_target_reg <= btb_tgt_reg[if_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      flush_reg          <= 1'b0;
    end else begin
      flush_reg <= upd_en & mis;
      if (redirect_valid_reg) begin
        if (redirect_ready) begin
          redirect_valid_reg <= 1'b0;
        end
      end else if (upd_en && mis) begin
        redirect_valid_reg <= 1'b1;
        redirect_pc_reg    <= redirect_pc_next;
      end
    end
  end

  assign pred_valid     = pred_valid_reg;
  assign pred_taken     = pred_taken_reg;
  assign pred_target    = pred_target_reg;
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;
  assign flush          = flush_reg;

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed vector table plus randomized traffic, each cycle checked against
// a behavioural predictor model kept in the bench.
module tb_branch_pred_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_valid = 1'b0;
  logic [31:0] if_req_pc = '0;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        redirect_valid;
  logic        redirect_ready = 1'b0;
  logic [31:0] redirect_pc;
  logic        flush;

  always #5 clk = ~clk;

  branch_pred_unit #(.XLEN(32), .BHT_DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_pc(if_req_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush(flush)
  );

  typedef struct {
    logic        rst;
    logic        ifv;
    logic [31:0] ifpc;
    logic        exv;
    logic [31:0] expc;
    logic        ext;
    logic [31:0] extgt;
    logic        expt;
    logic [31:0] exptgt;
    logic        rdy;
    logic        pv;
    logic        pt;
    logic [31:0] ptg;
    logic        rv;
    logic [31:0] rpc;
    logic        fl;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state: saturating counters as plain integers.
  int          m_cnt [64];
  bit          m_vld [64];
  logic [31:0] m_tgt [64];
  bit          m_pv, m_pt, m_rv, m_fl;
  logic [31:0] m_ptg, m_rpc;

  function automatic vec_t mk(
      input logic r, input logic ifv, input logic [31:0] ifpc,
      input logic exv, input logic [31:0] expc, input logic ext, input logic [31:0] extgt,
      input logic expt, input logic [31:0] exptgt, input logic rdy,
      input logic pv, input logic pt, input logic [31:0] ptg,
      input logic rv, input logic [31:0] rpc, input logic fl);
    vec_t v;
    v.rst = r; v.ifv = ifv; v.ifpc = ifpc; v.exv = exv; v.expc = expc;
    v.ext = ext; v.extgt = extgt; v.expt = expt; v.exptgt = exptgt; v.rdy = rdy;
    v.pv = pv; v.pt = pt; v.ptg = ptg; v.rv = rv; v.rpc = rpc; v.fl = fl;
    return v;
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc >> 2) % 64;
  endfunction

  task automatic model_step(input vec_t s);
    bit accepted;
    bit wrong;
    int k;
    if (s.rst) begin
      for (int i = 0; i < 64; i++) begin
        m_cnt[i] = 1; m_vld[i] = 0; m_tgt[i] = '0;
      end
      m_pv = 0; m_pt = 0; m_ptg = '0; m_rv = 0; m_rpc = '0; m_fl = 0;
      return;
    end
    accepted = s.exv && !m_rv;
    wrong = (s.expt != s.ext) || (s.ext && s.exptgt != s.extgt);
    if (s.ifv) begin
      k = idx_of(s.ifpc);
      m_pt  = m_vld[k] && (m_cnt[k] >= 2);
      m_ptg = m_tgt[k];
    end
    m_pv = s.ifv;
    m_fl = accepted && wrong;
    if (m_rv) begin
      if (s.rdy) m_rv = 0;
    end else if (accepted && wrong) begin
      m_rv  = 1;
      m_rpc = s.ext ? s.extgt : s.expc + 32'd4;
    end
    if (accepted) begin
      k = idx_of(s.expc);
      if (s.ext) begin
        if (m_cnt[k] < 3) m_cnt[k] = m_cnt[k] + 1;
        m_vld[k] = 1;
        m_tgt[k] = s.extgt;
      end else if (m_cnt[k] > 0) begin
        m_cnt[k] = m_cnt[k] - 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t s, input bit use_tbl, input int n);
    rst = s.rst; if_req_valid = s.ifv; if_req_pc = s.ifpc;
    ex_valid = s.exv; ex_pc = s.expc; ex_taken = s.ext; ex_target = s.extgt;
    ex_pred_taken = s.expt; ex_pred_target = s.exptgt; redirect_ready = s.rdy;
    model_step(s);
    @(posedge clk);
    #1;
    $display("txn %0d: rst=%0b if=%0b/%08h ex=%0b/%08h t=%0b rdy=%0b -> pv=%0b pt=%0b ptg=%08h rv=%0b rpc=%08h fl=%0b",
             n, s.rst, s.ifv, s.ifpc, s.exv, s.expc, s.ext, s.rdy,
             pred_valid, pred_taken, pred_target, redirect_valid, redirect_pc, flush);
    chk($sformatf("model[%0d] pred_valid", n), 32'(pred_valid), 32'(m_pv));
    chk($sformatf("model[%0d] pred_taken", n), 32'(pred_taken), 32'(m_pt));
    chk($sformatf("model[%0d] pred_target", n), pred_target, m_ptg);
    chk($sformatf("model[%0d] redirect_valid", n), 32'(redirect_valid), 32'(m_rv));
    chk($sformatf("model[%0d] flush", n), 32'(flush), 32'(m_fl));
    if (m_rv) chk($sformatf("model[%0d] redirect_pc", n), redirect_pc, m_rpc);
    if (use_tbl) begin
      chk($sformatf("vec[%0d] pred_valid", n), 32'(pred_valid), 32'(s.pv));
      chk($sformatf("vec[%0d] pred_taken", n), 32'(pred_taken), 32'(s.pt));
      chk($sformatf("vec[%0d] pred_target", n), pred_target, s.ptg);
      chk($sformatf("vec[%0d] redirect_valid", n), 32'(redirect_valid), 32'(s.rv));
      chk($sformatf("vec[%0d] flush", n), 32'(flush), 32'(s.fl));
      if (s.rv) chk($sformatf("vec[%0d] redirect_pc", n), redirect_pc, s.rpc);
    end
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0100;
      1: return 32'h0000_0200;   // aliases with 0x100
      2: return 32'h0000_0104;
      3: return 32'hFFFF_FFFC;
      default: return {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    endcase
  endfunction

  vec_t tbl [35];

  initial begin
    // rst ifv ifpc  exv expc  ext extgt expt exptgt rdy | pv pt ptg rv rpc fl
    tbl[0]  = mk(1,0,0,     0,0,0,0,0,0,0,           0,0,0,     0,0,0);
    tbl[1]  = mk(0,1,'h100, 0,0,0,0,0,0,0,           1,0,0,     0,0,0);
    tbl[2]  = mk(0,0,0,     1,'h100,1,'h200,0,0,0,   0,0,0,     1,'h200,1);
    tbl[3]  = mk(0,0,0,     0,0,0,0,0,0,0,           0,0,0,     1,'h200,0);
    tbl[4]  = mk(0,0,0,     0,0,0,0,0,0,1,           0,0,0,     0,0,0);
    tbl[5]  = mk(0,0,0,     1,'h100,1,'h200,1,'h200,0, 0,0,0,   0,0,0);
    tbl[6]  = mk(0,1,'h100, 0,0,0,0,0,0,0,           1,1,'h200, 0,0,0);
    tbl[7]  = mk(0,0,0,     1,'h100,1,'h200,1,'h200,0, 0,1,'h200, 0,0,0);
    tbl[8]  = mk(0,0,0,     1,'h100,1,'h200,1,'h200,0, 0,1,'h200, 0,0,0);
    tbl[9]  = mk(0,0,0,     1,'h100,1,'h200,1,'h200,0, 0,1,'h200, 0,0,0);
    tbl[10] = mk(0,0,0,     1,'h100,0,0,0,0,0,       0,1,'h200, 0,0,0);
    tbl[11] = mk(0,1,'h100, 0,0,0,0,0,0,0,           1,1,'h200, 0,0,0);
    tbl[12] = mk(0,0,0,     1,'h100,0,0,0,0,0,       0,1,'h200, 0,0,0);
    tbl[13] = mk(0,0,0,     1,'h100,0,0,0,0,0,       0,1,'h200, 0,0,0);
    tbl[14] = mk(0,0,0,     1,'h100,0,0,0,0,0,       0,1,'h200, 0,0,0);
    tbl[15] = mk(0,0,0,     1,'h100,1,'h200,1,'h200,0, 0,1,'h200, 0,0,0);
    tbl[16] = mk(0,1,'h100, 0,0,0,0,0,0,0,           1,0,'h200, 0,0,0);
    tbl[17] = mk(0,0,0,     1,'h100,1,'h200,1,'h200,0, 0,0,'h200, 0,0,0);
    tbl[18] = mk(0,1,'h100, 0,0,0,0,0,0,0,           1,1,'h200, 0,0,0);
    // backpressure: redirect held, wrong-path resolves ignored
    tbl[19] = mk(0,0,0,     1,'h100,0,0,1,0,0,       0,1,'h200, 1,'h104,1);
    tbl[20] = mk(0,0,0,     1,'h100,1,'h500,0,0,0,   0,1,'h200, 1,'h104,0);
    tbl[21] = mk(0,0,0,     1,'h100,1,'h500,0,0,0,   0,1,'h200, 1,'h104,0);
    tbl[22] = mk(0,0,0,     1,'h100,1,'h500,0,0,0,   0,1,'h200, 1,'h104,0);
    tbl[23] = mk(0,0,0,     0,0,0,0,0,0,0,           0,1,'h200, 1,'h104,0);
    tbl[24] = mk(0,0,0,     1,'h100,1,'h500,0,0,1,   0,1,'h200, 0,0,0);
    tbl[25] = mk(0,1,'h100, 0,0,0,0,0,0,0,           1,0,'h200, 0,0,0);
    // not-taken fall-through wraps past the top of the address space
    tbl[26] = mk(0,0,0,     1,'hFFFFFFFC,0,0,1,'h10,0, 0,0,'h200, 1,0,1);
    tbl[27] = mk(0,0,0,     0,0,0,0,0,0,1,           0,0,'h200, 0,0,0);
    // taken but wrong target
    tbl[28] = mk(0,0,0,     1,'h100,1,'h400,1,'h300,0, 0,0,'h200, 1,'h400,1);
    tbl[29] = mk(0,1,'h100, 0,0,0,0,0,0,1,           1,1,'h400, 0,0,0);
    // same-cycle lookup/update returns the old entry
    tbl[30] = mk(0,1,'h100, 1,'h100,1,'h600,1,'h600,0, 1,1,'h400, 0,0,0);
    tbl[31] = mk(0,1,'h100, 0,0,0,0,0,0,0,           1,1,'h600, 0,0,0);
    // reset aborts a pending redirect and clears the tables
    tbl[32] = mk(0,0,0,     1,'h100,0,0,1,0,0,       0,1,'h600, 1,'h104,1);
    tbl[33] = mk(1,0,0,     0,0,0,0,0,0,0,           0,0,0,     0,0,0);
    tbl[34] = mk(0,1,'h100, 0,0,0,0,0,0,0,           1,0,0,     0,0,0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 35; i++) apply(tbl[i], 1'b1, i);

    for (int i = 0; i < 1500; i++) begin
      vec_t s;
      s = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
      s.rst    = ($urandom_range(0, 99) == 0);
      s.ifv    = $urandom_range(0, 1) != 0;
      s.ifpc   = pick_pc();
      s.exv    = $urandom_range(0, 2) != 0;
      s.expc   = pick_pc();
      s.ext    = $urandom_range(0, 1) != 0;
      s.extgt  = 32'h1000 + 32'($urandom_range(0, 3)) * 32'h40;
      s.expt   = $urandom_range(0, 1) != 0;
      s.exptgt = ($urandom_range(0, 2) != 0) ? s.extgt : 32'h1000 + 32'($urandom_range(0, 3)) * 32'h40;
      s.rdy    = $urandom_range(0, 1) != 0;
      apply(s, 1'b0, 35 + i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
